// File: rtl/qsn_merge_len17.sv
// rtl/qsn_merge_len17.sv - merges 17-lane QSN left/right shifter outputs into a credit-flow-controlled output FIFO
// Optional range check on the shift factor is built when QSN_MERGE_SHIFT_CHK_EN is defined.
module qsn_merge_len17 #(
    parameter int PC      = 17,
    parameter int SHIFT_W = 5,
    parameter int LAT_LR  = 1,
    parameter int DEPTH   = 3
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SHIFT_W-1:0] shift_factor,
    input  logic [PC-2:0]      left_in,
    input  logic [PC-1:0]      right_in,
    output logic [PC-1:0]      out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               shift_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic               accept;
    logic [SHIFT_W-1:0] s_acc;
    logic               dl_v [LAT_LR];
    logic [SHIFT_W-1:0] dl_s [LAT_LR];
    logic [PC-1:0]      mem  [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [PC-1:0]      merged;
    logic               push;
    logic               pop;
    int                 thr;
    int                 cnt_n;
    int                 infl_n;

    assign accept    = in_valid && in_ready;
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign push      = dl_v[LAT_LR-1];
    assign pop       = out_valid && out_ready;

`ifdef QSN_MERGE_SHIFT_CHK_EN
    logic s_illegal;
    assign s_illegal = (int'(shift_factor) >= PC);
    assign s_acc     = s_illegal ? '0 : shift_factor;
`else
    assign s_acc     = shift_factor;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Lanes at or above PC-s wrap around and come from the right shifter; the top lane always does.
    always_comb begin
        thr    = (int'(dl_s[LAT_LR-1]) >= PC) ? 0 : PC - int'(dl_s[LAT_LR-1]);
        merged = '0;
        for (int i = 0; i < PC - 1; i++) begin
            merged[i] = (i >= thr) ? right_in[i] : left_in[i];
        end
        merged[PC-1] = right_in[PC-1];
    end

    // Credits count the beats that will be in the FIFO or the shifters after this edge.
    always_comb begin
        infl_n = accept ? 1 : 0;
        for (int k = 0; k < LAT_LR - 1; k++) begin
            infl_n = infl_n + (dl_v[k] ? 1 : 0);
        end
        cnt_n = int'(count) + (push ? 1 : 0) - (pop ? 1 : 0);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int k = 0; k < LAT_LR; k++) begin
                dl_v[k] <= 1'b0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else begin
            dl_v[0] <= accept;
            for (int k = 1; k < LAT_LR; k++) begin
                dl_v[k] <= dl_v[k-1];
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count    <= CNT_W'(cnt_n);
            in_ready <= (cnt_n + infl_n) < DEPTH;
        end
    end

    always_ff @(posedge sys_clk) begin
        dl_s[0] <= s_acc;
        for (int k = 1; k < LAT_LR; k++) begin
            dl_s[k] <= dl_s[k-1];
        end
        if (push && !rst) begin
            mem[wr_ptr] <= merged;
        end
    end

`ifdef QSN_MERGE_SHIFT_CHK_EN
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            shift_err <= 1'b0;
        end else if (accept && s_illegal) begin
            shift_err <= 1'b1;
        end
    end
`else
    assign shift_err = 1'b0;
`endif

endmodule

// File: tb/tb_qsn_merge_len17.sv
// tb/tb_qsn_merge_len17.sv - scoreboard bench for qsn_merge_len17 with shifter and rotation reference model
module tb_qsn_merge_len17;

    localparam int PC    = 17;
    localparam int DEPTH = 3;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  shift_factor = '0;
    logic [15:0] left_in = '0;
    logic [16:0] right_in = '0;
    logic [16:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        shift_err;

    qsn_merge_len17 dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .shift_factor (shift_factor),
        .left_in      (left_in),
        .right_in     (right_in),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .shift_err    (shift_err)
    );

    always #5 sys_clk = ~sys_clk;

    int          checks = 0;
    int          passes = 0;
    int          pops = 0;
    int          n_acc = 0;
    logic [16:0] exp_q [$];
    logic        pend = 1'b0;
    logic [4:0]  pend_s = '0;
    logic [16:0] pend_sw = '0;
    logic        hold_v = 1'b0;
    logic [16:0] hold_d = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Reference: output lane i carries input lane (i+s) mod 17.
    function automatic logic [16:0] rot(input logic [4:0] s, input logic [16:0] sw);
        logic [16:0] o;
        for (int i = 0; i < PC; i++) o[i] = sw[(i + int'(s)) % PC];
        return o;
    endfunction

    // Upstream shifter outputs for a beat; lanes the merge must ignore get random filler.
    task automatic present_shift(input logic [4:0] s, input logic [16:0] sw, output logic [16:0] want);
        logic [16:0] l;
        logic [16:0] r;
        int si;
        si = int'(s);
        l = 17'($urandom);
        r = 17'($urandom);
        if (si < PC) begin
            for (int i = 0; i < PC - 1; i++) if (i + si < PC) l[i] = sw[i + si];
            for (int i = 0; i < PC; i++) if (i + si >= PC || si == 0) r[i] = sw[(i + si) % PC];
            want = rot(s, sw);
        end else begin
            l = sw;
            r[16] = sw[16];
`ifdef QSN_MERGE_SHIFT_CHK_EN
            want = sw;
`else
            want = r;
`endif
        end
        left_in  = l[15:0];
        right_in = r;
    endtask

    task automatic step(input logic v, input logic [4:0] s, input logic [16:0] sw,
                        input logic ordy, input logic r);
        logic [16:0] e;
        @(negedge sys_clk);
        if (pend) begin
            present_shift(pend_s, pend_sw, e);
            if (!r) exp_q.push_back(e);
        end else begin
            left_in  = 16'($urandom);
            right_in = 17'($urandom);
        end
        if (r) exp_q.delete();
        rst          = r;
        in_valid     = v;
        shift_factor = s;
        out_ready    = ordy;
        pend         = v && in_ready && !r;
        pend_s       = s;
        pend_sw      = sw;
        if (pend) n_acc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 5'd0, 17'd0, 1'b1, 1'b0);
    endtask

    task automatic directed(input string name, input logic [4:0] s, input logic [16:0] sw,
                            input logic [16:0] want);
        step(1'b1, s, sw, 1'b1, 1'b0);
        chk({name, "_accept"}, pend, 1);
        idle(1);
        chk({name, "_t1_valid"}, out_valid, 0);
        idle(1);
        chk({name, "_t2_valid"}, out_valid, 1);
        chk({name, "_data"}, out_data, want);
    endtask

    // Monitor: pops the scoreboard on every DUT handshake, checks hold stability and overflow.
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge sys_clk);
            #1;
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                if (exp_q.size() > DEPTH) begin
                    checks++;
                    $display("FAIL fifo_overflow: %0d entries outstanding, limit %0d", exp_q.size(), DEPTH);
                end
                if (hold_v) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, hold_d);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_out: got %0h, required no output", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e);
                        pops++;
                    end
                end
                hold_v = out_valid && !out_ready;
                hold_d = out_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int drops;
        int bubbles;
        int p0;
        int a0;
        logic [4:0] s;
        logic [16:0] sw;

        step(1'b0, 5'd0, 17'd0, 1'b0, 1'b1);
        step(1'b0, 5'd0, 17'd0, 1'b0, 1'b1);
        step(1'b0, 5'd0, 17'd0, 1'b0, 1'b0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_shift_err", shift_err, 0);
        chk("reset_in_ready", in_ready, 1);

        directed("single_s5", 5'd5, 17'h00001, 17'h01000);
        idle(2);
        directed("bound_s0", 5'd0, 17'h10000, 17'h10000);
        idle(2);
        directed("bound_s16", 5'd16, 17'h00001, 17'h00002);
        idle(2);

        drops = 0;
        bubbles = 0;
        p0 = pops;
        for (int k = 0; k < 50; k++) begin
            s  = 5'($urandom_range(0, 16));
            sw = 17'($urandom);
            step(1'b1, s, sw, 1'b1, 1'b0);
            if (!pend) drops++;
            if (k >= 2 && !out_valid) bubbles++;
        end
        idle(4);
        chk("stream_ready_drops", drops, 0);
        chk("stream_bubbles", bubbles, 0);
        chk("stream_pops", pops - p0, 50);

        a0 = n_acc;
        p0 = pops;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 5'($urandom_range(0, 16)), 17'($urandom), 1'b0, 1'b0);
            if (k == 3) chk("bp_ready_low", in_ready, 0);
        end
        chk("bp_accepts", n_acc - a0, 3);
        step(1'b0, 5'd0, 17'd0, 1'b1, 1'b0);
        chk("bp_ready_before_pop", in_ready, 0);
        step(1'b0, 5'd0, 17'd0, 1'b1, 1'b0);
        chk("bp_ready_return", in_ready, 1);
        idle(3);
        chk("bp_drain_pops", pops - p0, 3);

        chk("pre_illegal_err", shift_err, 0);
        step(1'b1, 5'd20, 17'h1A5C3, 1'b1, 1'b0);
        idle(1);
`ifdef QSN_MERGE_SHIFT_CHK_EN
        chk("illegal_shift_err", shift_err, 1);
`else
        chk("illegal_shift_err", shift_err, 0);
`endif
        idle(3);

        for (int k = 0; k < 3; k++) step(1'b1, 5'($urandom_range(0, 16)), 17'($urandom), 1'b0, 1'b0);
        step(1'b0, 5'd0, 17'd0, 1'b0, 1'b1);
        step(1'b0, 5'd0, 17'd0, 1'b0, 1'b0);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_shift_err", shift_err, 0);
        idle(4);
        chk("rst_no_stale", out_valid, 0);
        sw = 17'($urandom);
        directed("post_reset", 5'd3, sw, rot(5'd3, sw));

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1);
        idle(2);
        chk("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/qsn_merge_len17.md
# qsn_merge_len17

Merge-and-buffer stage placed directly downstream of the 17-lane QSN left and right shifters. It aligns each accepted shift factor with the shifter outputs, selects left or right lanes per output position to form the full cyclic left shift of the 17-lane circulant, and holds results in a small output FIFO with valid/ready handshake. It also issues `in_ready` to the source that drives both shifters, using credits so that in-flight shifter beats can never overflow the FIFO.

## Interface
- `PC`, 17: circulant size, i.e. number of output lanes.
- `SHIFT_W`, 5: shift-factor width.
- `LAT_LR`, 1: cycles from shifter input sample to shifter output valid. Must be ≥1.
- `DEPTH`, 3: output FIFO entries. Must be ≥ `LAT_LR`+2.

Ports (synchronous, active-high reset `rst`):
- `sys_clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous active-high reset.
- `in_valid` in 1: the source presents a beat to both shifters and to this block this cycle.
- `in_ready` out 1: a beat is accepted when `in_valid && in_ready`.
- `shift_factor` in `SHIFT_W`: cyclic left-shift amount s of the accepted beat. Legal range 0..16.
- `left_in` in `PC-1`: left shifter output; `left_in[i]` = `sw_in[i+s]`.
- `right_in` in `PC`: right shifter output, programmed with shift (17−s) mod 17; `right_in[i]` = `sw_in[i+s−17]` for i ≥ 17−s.
- `out_data` out `PC`: merged word at the FIFO head.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer pops the head when `out_valid && out_ready`.
- `shift_err` out 1: sticky flag for an illegal shift factor.

## Operation
- **Accept.** On accept in cycle T, push `{1'b1, s}` into an `LAT_LR`-deep valid/shift delay line. Non-accepted cycles push `{0, x}`.
- **Merge.** In cycle T+`LAT_LR`, the delay-line tail is valid and `left_in`/`right_in` carry beat T.
  - Mask: lane i takes `right_in[i]` iff i ≥ 17−s or i = 16; otherwise it takes `left_in[i]`.
  - s = 0 selects `right_in[16]` only.
  - The merged word is written to the FIFO at the end of that cycle.
- **FIFO.** Circular buffer of `DEPTH` entries with wrapping read and write pointers and a count of 0..`DEPTH`.
  - Push and pop in the same cycle leave the count unchanged.
  - Pop from an empty FIFO never happens because `out_valid` is 0.
- **Credits.** `inflight` is the number of valid delay-line entries. `in_ready = (count + inflight) < DEPTH`.
  - `in_ready` is a registered function of state only; there is no combinational path from `out_ready`.
  - A push therefore never meets a full FIFO. An overflow is an assertion failure in the bench.
- **Shift range check.** Applies when the feature is compiled in; see Configuration.
  - s ≥ 17 on an accepted beat sets `shift_err` the following cycle.
  - That beat's mask is computed as s = 0.
  - `shift_err` stays set until `rst`.
- **Reset mid-operation.** Delay line, FIFO pointers and count clear; in-flight and buffered beats are discarded. Shifter outputs arriving after reset are ignored because the delay-line valids are 0.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `shift_err`=0, count=0, delay line all invalid.
- `in_ready`=1 in the first cycle after `rst` deasserts.
- Latency: accept at T → `out_valid` at T+`LAT_LR`+1 (T+2 at defaults), provided the FIFO was empty.
- Throughput: one beat per cycle sustained while `out_ready`=1.
- Backpressure: with `out_ready`=0, at most `DEPTH` beats are accepted before `in_ready` drops.
  - `in_ready` rises the cycle after a pop frees a credit.
- `out_data` is stable while `out_valid && !out_ready`.

## Configuration
- `QSN_MERGE_SHIFT_CHK_EN` defined: the range check and the sticky `shift_err` are built, and an illegal s is remapped to 0.
- Not defined: `shift_err` is tied to 0, and the mask is computed from raw s with 17−s saturating at 0, so s ≥ 17 selects `right_in` on all lanes.

## Test plan
- **Single beat.** After reset, one beat with s=5, `sw_in`=17'h00001. → `out_valid` at T+2, `out_data`=17'h01000 (bit 12 set); lanes 12..16 come from `right_in`.
- **s=0 and s=16 bounds.** s=0 with `sw_in`=17'h10000 → `out_data`=17'h10000. s=16 with `sw_in`=17'h00001 → `out_data`=17'h00002.
- **Streaming.** 50 consecutive beats with random s in 0..16 and `out_ready`=1 → `in_ready` stays 1, outputs match the reference cyclic shift in order, and there is no bubble after the first.
- **Backpressure.** `out_ready`=0 with continuous `in_valid` → exactly 3 beats accepted and `in_ready`=0 from the cycle after the 3rd accept. Releasing `out_ready` drains 3 words in order, and `in_ready` returns 1 the cycle after the first pop.
- **Illegal shift.** s=20 with the macro defined → `shift_err`=1 one cycle after accept and `out_data` = the unshifted `sw_in`. Without the macro → `out_data`=`right_in` and `shift_err`=0.
- **Reset mid-stream.** `rst` pulsed while 2 beats are buffered and 1 is in flight → the next cycle has `out_valid`=0 and `in_ready`=1. No stale word appears afterwards.
